cmd_exec: RTL and testbench
===========================

CMD_EXEC -- requirements
Module: cmd_exec

Interface
REQ-001 Parameter: WIDTH, 64, operand/result width in bits.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 Port: rdy_i  input  1  upstream command-present qualifier, one command per asserted cycle.
REQ-005 Port: cmd_i  input  3  command code of type CMD_TYPE.
REQ-006 Port: opd1_i  input  WIDTH  first operand, unsigned.
REQ-007 Port: opd2_i  input  WIDTH  second operand, unsigned.
REQ-008 Port: busy_o  output  1  high when the block cannot accept a command this cycle.
REQ-009 Port: done_o  output  1  one-cycle completion pulse.
REQ-010 Port: done_cmd_o  output  3  code of the completed command, valid with done_o.
REQ-011 Port: result_o  output  WIDTH  result of the completed command, held until the next done_o.
REQ-012 Port: err_o  output  1  divide-by-zero flag, valid with done_o.
REQ-013 Port: drop_cnt_o  output  8  saturating count of dropped commands.

Function
REQ-014 Accept: a command is accepted on a rising edge where rdy_i=1, busy_o=0 and state is IDLE.
REQ-015 Drop: rdy_i=1 while busy_o=1 discards the command and increments drop_cnt_o, saturating at 255.
REQ-016 FSM states: IDLE, ITER, HALT; busy_o=1 in ITER and HALT, 0 in IDLE.
REQ-017 Single-cycle ops (RST, INIT, ADD, SUB, HLT) complete with done_o=1 on the cycle after acceptance.
REQ-018 RST: result_o<=0, accumulator<=0, done_cmd_o=RST.
REQ-019 INIT: accumulator<=opd1_i, result_o<=opd1_i.
REQ-020 ADD: result_o<=(opd1_i+opd2_i) mod 2^WIDTH, carry discarded; SUB: result_o<=(opd1_i-opd2_i) mod 2^WIDTH, borrow discarded.
REQ-021 MULT: shift-add over WIDTH iterations; result_o = low WIDTH bits of the product; done_o asserted exactly WIDTH+1 cycles after acceptance.
REQ-022 DIV/REM: restoring division over WIDTH iterations; DIV gives the quotient, REM the remainder; done_o asserted WIDTH+1 cycles after acceptance.
REQ-023 Divide by zero (opd2_i=0 with DIV/REM): no iteration; done_o on the next cycle with err_o=1; result_o = all ones (DIV) or opd1_i (REM).
REQ-024 Transitions: IDLE->ITER on an accepted MULT/DIV/REM with a nonzero divisor; ITER->IDLE on the completing cycle; IDLE->HALT on an accepted HLT.
REQ-025 HALT: done_o pulses once for HLT; thereafter only cmd_i=RST with rdy_i=1 is accepted (HALT->IDLE, RST completion); any other command is dropped per REQ-015.
REQ-026 busy_o falls in the cycle done_o is asserted for an iterative op, so a back-to-back command is accepted on that edge.
REQ-027 err_o=0 with every done_o except REQ-023.
REQ-028 Operands and cmd_i are registered at acceptance; later input changes do not affect an in-flight op.
REQ-029 done_o is never asserted in two consecutive cycles for the same command.

Reset
REQ-030 rst=0 asynchronously forces state=IDLE, busy_o=0, done_o=0, done_cmd_o=0, result_o=0, err_o=0, drop_cnt_o=0, accumulator=0 and the iteration counter=0.
REQ-031 Reset asserted mid-iteration aborts the operation with no done_o; release takes effect on the first rising clk edge after rst=1.

Structure
REQ-032 Package cmd_pkg SHALL hold the CMD_TYPE enum (RST=0, INIT=1, ADD=2, SUB=3, MULT=4, DIV=5, REM=6, HLT=7) and the WIDTH default.
REQ-033 The iterative multiply/divide datapath SHALL be one sub-module, cmd_iter_unit, with start/op/busy/finish handshake; the FSM and result mux stay in cmd_exec.

Verification
REQ-034 ADD opd1=5, opd2=7 -> next cycle done_o=1, done_cmd_o=ADD, result_o=12, err_o=0.
REQ-035 SUB opd1=0, opd2=1 -> result_o=64'hFFFF_FFFF_FFFF_FFFF, done one cycle later.
REQ-036 MULT 3x4 -> busy_o high 64 cycles, done_o at acceptance+65 with result_o=12; an ADD presented mid-op is dropped and drop_cnt_o=1.
REQ-037 DIV 100/7 -> result_o=14; REM 100/7 -> result_o=2; DIV 9/0 -> next-cycle done_o, err_o=1, result_o=all ones.
REQ-038 HLT, then ADD, then RST -> one HLT done, ADD dropped (drop_cnt_o+1), RST done with result_o=0, state back to IDLE.
REQ-039 rst=0 at iteration 30 of DIV -> all outputs 0 immediately, no done_o; a following ADD 1+1 completes normally with result_o=2.

Source files
------------

// File: rtl/cmd_pkg.sv
// Shared types for the command executor: command codes and default width.
// Imported by the interface, the iterative unit and the top.
package cmd_pkg;

    localparam int CMD_WIDTH = 64;

    typedef enum logic [2:0] {
        RST  = 3'd0,
        INIT = 3'd1,
        ADD  = 3'd2,
        SUB  = 3'd3,
        MULT = 3'd4,
        DIV  = 3'd5,
        REM  = 3'd6,
        HLT  = 3'd7
    } CMD_TYPE;

    function automatic logic is_divide(input CMD_TYPE c);
        return (c == DIV) || (c == REM);
    endfunction

endpackage

// File: rtl/cmd_exec_if.sv
// Command/response bundle between an issuer (master) and cmd_exec (slave).
// One command per cycle with rdy_i high; completion reported with done_o.
interface cmd_exec_if #(
    parameter int WIDTH = cmd_pkg::CMD_WIDTH
);
    import cmd_pkg::*;

    logic             rdy_i;
    CMD_TYPE          cmd_i;
    logic [WIDTH-1:0] opd1_i;
    logic [WIDTH-1:0] opd2_i;
    logic             busy_o;
    logic             done_o;
    CMD_TYPE          done_cmd_o;
    logic [WIDTH-1:0] result_o;
    logic             err_o;
    logic [7:0]       drop_cnt_o;

    modport master (
        output rdy_i, cmd_i, opd1_i, opd2_i,
        input  busy_o, done_o, done_cmd_o, result_o, err_o, drop_cnt_o
    );

    modport slave (
        input  rdy_i, cmd_i, opd1_i, opd2_i,
        output busy_o, done_o, done_cmd_o, result_o, err_o, drop_cnt_o
    );

endinterface

// File: rtl/cmd_iter_unit.sv
// Bit-serial datapath: shift-add multiply and restoring divide, one bit
// per clock over WIDTH clocks; o_result is the value of the final step.
module cmd_iter_unit
    import cmd_pkg::*;
#(
    parameter int WIDTH = CMD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  CMD_TYPE          i_op,
    input  logic [WIDTH-1:0] i_opa,
    input  logic [WIDTH-1:0] i_opb,
    output logic             o_busy,
    output logic             o_finish,
    output logic [WIDTH-1:0] o_result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             r_busy;
    CMD_TYPE          r_op;
    logic [CW-1:0]    r_cnt;
    // r_x: multiplicand (MULT) or dividend/quotient shifter (DIV/REM)
    logic [WIDTH-1:0] r_x;
    // r_y: multiplier (MULT) or divisor (DIV/REM)
    logic [WIDTH-1:0] r_y;
    // r_acc: partial product (MULT) or partial remainder (DIV/REM)
    logic [WIDTH-1:0] r_acc;

    logic [WIDTH-1:0] w_m_acc;
    logic [WIDTH:0]   w_sh;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_d_rem;
    logic [WIDTH-1:0] w_d_q;
    logic [WIDTH-1:0] w_x_nxt;
    logic [WIDTH-1:0] w_y_nxt;
    logic [WIDTH-1:0] w_acc_nxt;

    // One step of either algorithm; the borrow bit of w_diff decides restore.
    always_comb begin
        w_m_acc = r_y[0] ? (r_acc + r_x) : r_acc;
        w_sh    = {r_acc, r_x[WIDTH-1]};
        w_diff  = w_sh - {1'b0, r_y};
        w_ge    = ~w_diff[WIDTH];
        w_d_rem = w_ge ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0];
        w_d_q   = {r_x[WIDTH-2:0], w_ge};
        if (r_op == MULT) begin
            w_x_nxt   = r_x << 1;
            w_y_nxt   = r_y >> 1;
            w_acc_nxt = w_m_acc;
        end else begin
            w_x_nxt   = w_d_q;
            w_y_nxt   = r_y;
            w_acc_nxt = w_d_rem;
        end
    end

    // Load operands on start, then iterate until the last bit is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_op   <= MULT;
            r_cnt  <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_acc  <= '0;
        end else if (i_start && !r_busy) begin
            r_busy <= 1'b1;
            r_op   <= i_op;
            r_cnt  <= '0;
            r_x    <= i_opa;
            r_y    <= i_opb;
            r_acc  <= '0;
        end else if (r_busy) begin
            r_x   <= w_x_nxt;
            r_y   <= w_y_nxt;
            r_acc <= w_acc_nxt;
            if (r_cnt == LAST) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_busy   = r_busy;
    assign o_finish = (r_cnt == LAST);
    assign o_result = (r_op == MULT) ? w_m_acc :
                      (r_op == DIV)  ? w_d_q   : w_d_rem;

endmodule

// File: rtl/cmd_exec.sv
// Command executor: accept/drop control, IDLE/ITER/HALT sequencing and
// result selection; multiply/divide iterations run in cmd_iter_unit.
module cmd_exec
    import cmd_pkg::*;
#(
    parameter int WIDTH = CMD_WIDTH
) (
    input  logic     clk,
    input  logic     rst,
    cmd_exec_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic [1:0]       r_state;
    logic             r_done;
    CMD_TYPE          r_cmd;
    CMD_TYPE          r_pcmd;
    logic [WIDTH-1:0] r_res;
    logic             r_err;
    logic [7:0]       r_drop;
    logic [WIDTH-1:0] r_acc;

    logic             w_idle;
    logic             w_accept;
    logic             w_halt_rst;
    logic             w_drop;
    logic             w_div0;
    logic             w_start;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_sc_res;
    logic             w_it_busy;
    logic             w_it_fin;
    logic [WIDTH-1:0] w_it_res;

    assign w_idle     = (r_state == S_IDLE);
    assign w_accept   = bus.rdy_i && w_idle;
    assign w_halt_rst = bus.rdy_i && (r_state == S_HALT) &&
                        (bus.cmd_i == RST);
    assign w_drop     = bus.rdy_i && !w_idle && !w_halt_rst;
    assign w_div0     = is_divide(bus.cmd_i) && (bus.opd2_i == '0);
    assign w_start    = w_accept &&
                        ((bus.cmd_i == MULT) ||
                         (is_divide(bus.cmd_i) && !w_div0));

    // Accumulator follows RST/INIT; everything else leaves it alone.
    always_comb begin
        w_acc_nxt = r_acc;
        if (w_halt_rst || (w_accept && bus.cmd_i == RST)) begin
            w_acc_nxt = '0;
        end else if (w_accept && bus.cmd_i == INIT) begin
            w_acc_nxt = bus.opd1_i;
        end
    end

    // Result of commands that finish on the cycle after acceptance.
    always_comb begin
        w_sc_res = r_res;
        case (bus.cmd_i)
            RST, INIT: w_sc_res = w_acc_nxt;
            ADD:       w_sc_res = bus.opd1_i + bus.opd2_i;
            SUB:       w_sc_res = bus.opd1_i - bus.opd2_i;
            DIV:       w_sc_res = '1;
            REM:       w_sc_res = bus.opd1_i;
            default:   w_sc_res = r_res;
        endcase
    end

    cmd_iter_unit #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk     (clk),
        .rst_n   (rst),
        .i_start (w_start),
        .i_op    (bus.cmd_i),
        .i_opa   (bus.opd1_i),
        .i_opb   (bus.opd2_i),
        .o_busy  (w_it_busy),
        .o_finish(w_it_fin),
        .o_result(w_it_res)
    );

    // Sequencing, completion pulse, held result and saturating drop count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
            r_cmd   <= RST;
            r_pcmd  <= RST;
            r_res   <= '0;
            r_err   <= 1'b0;
            r_drop  <= '0;
            r_acc   <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_acc  <= w_acc_nxt;
            if (w_drop && r_drop != 8'hFF) begin
                r_drop <= r_drop + 8'd1;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_ITER;
                        r_pcmd  <= bus.cmd_i;
                    end else if (w_accept) begin
                        r_done <= 1'b1;
                        r_cmd  <= bus.cmd_i;
                        r_err  <= w_div0;
                        if (bus.cmd_i == HLT) begin
                            r_state <= S_HALT;
                        end else begin
                            r_res <= w_sc_res;
                        end
                    end
                end
                S_ITER: begin
                    if (w_it_busy && w_it_fin) begin
                        r_done  <= 1'b1;
                        r_cmd   <= r_pcmd;
                        r_res   <= w_it_res;
                        r_state <= S_IDLE;
                    end
                end
                S_HALT: begin
                    if (w_halt_rst) begin
                        r_done  <= 1'b1;
                        r_cmd   <= RST;
                        r_res   <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy_o     = !w_idle;
    assign bus.done_o     = r_done;
    assign bus.done_cmd_o = r_cmd;
    assign bus.result_o   = r_res;
    assign bus.err_o      = r_err;
    assign bus.drop_cnt_o = r_drop;

endmodule

// File: tb/tb_cmd_exec.sv
// Bench for cmd_exec: directed scenarios plus random traffic, every cycle
// checked against a transaction-level model of accept/drop and latency.
module tb_cmd_exec;
    import cmd_pkg::*;

    localparam int W = 64;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cmd_exec_if #(.WIDTH(W)) bus();

    cmd_exec #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // model: 0 idle, 1 iterating, 2 halted
    int          m_mode;
    int          m_left;
    logic [63:0] m_res;
    logic [63:0] m_pend;
    CMD_TYPE     m_cmd;
    CMD_TYPE     m_pcmd;
    logic        m_done;
    logic        m_err;
    int          m_drop;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_mode = 0;
        m_left = 0;
        m_res  = '0;
        m_pend = '0;
        m_cmd  = RST;
        m_pcmd = RST;
        m_done = 1'b0;
        m_err  = 1'b0;
        m_drop = 0;
    endtask

    task automatic m_accept(input CMD_TYPE c, input logic [63:0] a,
                            input logic [63:0] b);
        m_done = 1'b1;
        m_cmd  = c;
        case (c)
            RST:  m_res = '0;
            INIT: m_res = a;
            ADD:  m_res = a + b;
            SUB:  m_res = a - b;
            HLT:  m_mode = 2;
            default: begin
                if (c != MULT && b == 0) begin
                    m_err = 1'b1;
                    m_res = (c == DIV) ? 64'hFFFF_FFFF_FFFF_FFFF : a;
                end else begin
                    m_done = 1'b0;
                    m_mode = 1;
                    m_left = W;
                    m_pcmd = c;
                    if (c == MULT)     m_pend = a * b;
                    else if (c == DIV) m_pend = a / b;
                    else               m_pend = a % b;
                end
            end
        endcase
    endtask

    task automatic m_step(input logic r, input CMD_TYPE c,
                          input logic [63:0] a, input logic [63:0] b);
        int was;
        was    = m_mode;
        m_done = 1'b0;
        m_err  = 1'b0;
        if (was == 1) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1'b1;
                m_res  = m_pend;
                m_cmd  = m_pcmd;
                m_mode = 0;
            end
        end
        if (r) begin
            if (was == 0) begin
                m_accept(c, a, b);
            end else if (was == 2 && c == RST) begin
                m_done = 1'b1;
                m_cmd  = RST;
                m_res  = '0;
                m_mode = 0;
            end else if (m_drop < 255) begin
                m_drop++;
            end
        end
    endtask

    task automatic check_outputs();
        chk("busy", 64'(bus.busy_o), 64'(m_mode != 0));
        chk("done", 64'(bus.done_o), 64'(m_done));
        chk("result", bus.result_o, m_res);
        chk("err", 64'(bus.err_o), 64'(m_err));
        chk("drop", 64'(bus.drop_cnt_o), 64'(m_drop));
        if (m_done) chk("done_cmd", 64'(bus.done_cmd_o), 64'(m_cmd));
    endtask

    task automatic cyc(input logic r, input CMD_TYPE c,
                       input logic [63:0] a, input logic [63:0] b);
        bus.rdy_i  = r;
        bus.cmd_i  = c;
        bus.opd1_i = a;
        bus.opd2_i = b;
        @(posedge clk);
        m_step(r, c, a, b);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, RST, '0, '0);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            cyc(1'b0, RST, '0, '0);
            n++;
        end while (!bus.done_o && n < 200);
        chk("wait_done", 64'(bus.done_o), 64'd1);
    endtask

    function automatic logic [63:0] rnd_opd();
        case ($urandom_range(0, 3))
            0:       return 64'($urandom_range(0, 20));
            1:       return '0;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(bus.busy_o), 64'd0);
        chk({tag, "_done"}, 64'(bus.done_o), 64'd0);
        chk({tag, "_cmd"}, 64'(bus.done_cmd_o), 64'd0);
        chk({tag, "_res"}, bus.result_o, 64'd0);
        chk({tag, "_err"}, 64'(bus.err_o), 64'd0);
        chk({tag, "_drop"}, 64'(bus.drop_cnt_o), 64'd0);
    endtask

    initial begin
        int n;
        bus.rdy_i  = 1'b0;
        bus.cmd_i  = RST;
        bus.opd1_i = '0;
        bus.opd2_i = '0;
        m_reset();
        rst = 1'b1;
        #3 rst = 1'b0;
        #10;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        cyc(1'b1, ADD, 64'd5, 64'd7);
        chk("add_done", 64'(bus.done_o), 64'd1);
        chk("add_res", bus.result_o, 64'd12);
        chk("add_cmd", 64'(bus.done_cmd_o), 64'(ADD));
        chk("add_err", 64'(bus.err_o), 64'd0);

        cyc(1'b1, SUB, 64'd0, 64'd1);
        chk("sub_res", bus.result_o, 64'hFFFF_FFFF_FFFF_FFFF);

        cyc(1'b1, MULT, 64'd3, 64'd4);
        chk("mult_busy", 64'(bus.busy_o), 64'd1);
        for (int i = 1; i <= 64; i++) begin
            cyc(i == 30, ADD, 64'd1, 64'd1);
            if (i < 64) chk("mult_early", 64'(bus.done_o), 64'd0);
        end
        chk("mult_done", 64'(bus.done_o), 64'd1);
        chk("mult_res", bus.result_o, 64'd12);
        chk("mult_drop", 64'(bus.drop_cnt_o), 64'd1);
        chk("mult_free", 64'(bus.busy_o), 64'd0);

        cyc(1'b1, DIV, 64'd100, 64'd7);
        wait_done(n);
        chk("div_lat", 64'(n + 1), 64'd65);
        chk("div_res", bus.result_o, 64'd14);
        cyc(1'b1, REM, 64'd100, 64'd7);
        wait_done(n);
        chk("rem_res", bus.result_o, 64'd2);
        cyc(1'b1, DIV, 64'd9, 64'd0);
        chk("div0_done", 64'(bus.done_o), 64'd1);
        chk("div0_err", 64'(bus.err_o), 64'd1);
        chk("div0_res", bus.result_o, 64'hFFFF_FFFF_FFFF_FFFF);
        cyc(1'b1, REM, 64'd9, 64'd0);
        chk("rem0_res", bus.result_o, 64'd9);

        cyc(1'b1, HLT, '0, '0);
        chk("hlt_done", 64'(bus.done_o), 64'd1);
        cyc(1'b1, ADD, 64'd1, 64'd2);
        chk("hlt_drop", 64'(bus.drop_cnt_o), 64'd2);
        cyc(1'b1, RST, '0, '0);
        chk("hlt_rst", 64'(bus.done_cmd_o), 64'(RST));
        chk("hlt_idle", 64'(bus.busy_o), 64'd0);

        cyc(1'b1, DIV, {$urandom, $urandom}, 64'd3);
        idle(29);
        #2 rst = 1'b0;
        #1;
        check_all_zero("abort");
        m_reset();
        @(negedge clk);
        chk("abort_hold", 64'(bus.done_o), 64'd0);
        rst = 1'b1;
        cyc(1'b1, ADD, 64'd1, 64'd1);
        chk("post_res", bus.result_o, 64'd2);
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 1)),
                CMD_TYPE'($urandom_range(0, 7)),
                rnd_opd(), rnd_opd());
        end

        idle(70);
        cyc(1'b1, RST, '0, '0);
        idle(1);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, MULT, rnd_opd(), rnd_opd());
            for (int i = 0; i < 64; i++) cyc(1'b1, ADD, 64'd1, 64'd1);
        end
        chk("drop_sat", 64'(bus.drop_cnt_o), 64'd255);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
